// File: rtl/fir_ntap_pkg.sv
// Shared types and helpers for the time-multiplexed N-tap FIR.
package fir_ntap_pkg;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

  localparam int RW = 64;

  typedef struct packed {
    logic              sat;
    logic signed [RW-1:0] val;
  } rnd_t;

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Round half up, arithmetic shift, then clamp to the signed out_w range.
  function automatic rnd_t sat_round(input logic signed [RW-1:0] acc, input int frac,
                                     input int out_w);
    logic signed [RW-1:0] half, r, mx, mn;
    rnd_t res;
    half = 64'sd1 <<< (frac - 1);
    r    = (acc + half) >>> frac;
    mx   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn   = -(64'sd1 <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > mx) begin
      res.sat = 1'b1;
      res.val = mx;
    end else if (r < mn) begin
      res.sat = 1'b1;
      res.val = mn;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_ntap_mac_coef_bank.sv
// Coefficient register file: guarded write port, combinational read by tap index.
module fir_coef_bank
  import fir_ntap_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int COEF_W = 16,
  parameter int AW     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic                     wr_ok,
  input  logic [AW-1:0]            ridx,
  output logic signed [COEF_W-1:0] rdata,
  output logic                     drop
);

  logic signed [COEF_W-1:0] c [TAPS];
  logic                     hit;

  assign hit   = we && wr_ok && ({1'b0, addr} < (AW+1)'(TAPS));
  assign rdata = c[ridx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) c[k] <= '0;
      drop <= 1'b0;
    end else begin
      drop <= we && !hit;
      if (hit) c[addr] <= wdata;
    end
  end

endmodule

// File: rtl/fir_ntap_mac.sv
// N-tap direct-form FIR, one multiply-accumulate per cycle, with handshakes.
module fir_ntap_mac
  import fir_ntap_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int TAPS   = 8,
  parameter int FRAC   = 15,
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS),
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_drop,
  output logic                     busy
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_t               state, nstate;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            idx;
  logic signed [COEF_W-1:0] c_rd;
  logic signed [PW-1:0]     prod;
  rnd_t                     rnd;

  fir_coef_bank #(.TAPS(TAPS), .COEF_W(COEF_W), .AW(AW)) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_we),
    .addr  (coef_addr),
    .wdata (coef_wdata),
    .wr_ok (state == IDLE),
    .ridx  (idx),
    .rdata (c_rd),
    .drop  (coef_drop)
  );

  assign prod = x[idx] * c_rd;
  assign rnd  = sat_round(RW'(acc), FRAC, OUT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (clear) nstate = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) nstate = MAC;
        MAC:     if (idx == LAST) nstate = ROUND;
        ROUND:   nstate = OUT;
        OUT:     if (out_ready) nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Datapath; clear wipes history and any in-flight result but keeps coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x[0] <= in_data;
          for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= (idx == LAST) ? '0 : idx + AW'(1);
        end
        ROUND: begin
          out_data  <= rnd.val[OUT_W-1:0];
          out_sat   <= rnd.sat;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
